// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: opcodes, control enums and the decoded payload.
// All control values here map one-to-one onto the decode_stage output ports.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    alu_op_e     alu_op;
    br_op_e      br_op;
    logic        branch;
    a_sel_e      a_sel;
    logic        b_sel;
    wb_sel_e     wb_sel;
    logic        rd_wren;
    logic        mem_rden;
    logic        mem_wren;
    logic        illegal;
    logic [2:0]  lsu_op;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

  // alt selects SUB/SRA; it is instr[30] for register ops.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_instr_dec.sv
// Combinational RV32I decoder: instruction word -> dec_t control payload.
// Illegal encodings keep their register fields but carry no side effects and a zero immediate.
module instr_dec
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        legal;
  logic        writes_rd;
  dec_t        d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'd0, instr[24:20]};

  always_comb begin
    d          = '0;
    d.rs1_addr = instr[19:15];
    d.rs2_addr = instr[24:20];
    d.rd_addr  = instr[11:7];
    legal      = 1'b1;
    writes_rd  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d.a_sel = A_ZERO; d.b_sel = 1'b1; d.imm = imm_u; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        d.a_sel = A_PC; d.b_sel = 1'b1; d.imm = imm_u; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        d.a_sel = A_PC; d.b_sel = 1'b1; d.imm = imm_j; d.br_op = BR_JAL;
        d.branch = 1'b1; d.wb_sel = WB_PC4; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        d.b_sel = 1'b1; d.imm = imm_i; d.br_op = BR_JALR;
        d.branch = 1'b1; d.wb_sel = WB_PC4; writes_rd = 1'b1;
        legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.a_sel = A_PC; d.b_sel = 1'b1; d.imm = imm_b; d.branch = 1'b1;
        case (funct3)
          3'b000:  d.br_op = BR_BEQ;
          3'b001:  d.br_op = BR_BNE;
          3'b100:  d.br_op = BR_BLT;
          3'b101:  d.br_op = BR_BGE;
          3'b110:  d.br_op = BR_BLTU;
          3'b111:  d.br_op = BR_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.b_sel = 1'b1; d.imm = imm_i; d.mem_rden = 1'b1; d.wb_sel = WB_LOAD;
        d.lsu_op = funct3; writes_rd = 1'b1;
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        d.b_sel = 1'b1; d.imm = imm_s; d.mem_wren = 1'b1; d.lsu_op = funct3;
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_OP_IMM: begin
        d.b_sel = 1'b1; d.imm = imm_i; writes_rd = 1'b1;
        d.alu_op = alu_from_f3(funct3, 1'b0);
        // Shift-immediates reuse the upper immediate bits as a function field.
        if (funct3 == 3'b001) begin
          d.imm = imm_sh;
          legal = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
          d.imm    = imm_sh;
          d.alu_op = alu_from_f3(funct3, instr[30]);
          legal    = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        d.alu_op  = alu_from_f3(funct3, instr[30]);
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      default: legal = 1'b0;
    endcase

    d.rd_wren = writes_rd && (d.rd_addr != 5'd0);

    if (!legal) begin
      d.imm      = '0;
      d.alu_op   = ALU_ADD;
      d.br_op    = BR_BEQ;
      d.branch   = 1'b0;
      d.a_sel    = A_RS1;
      d.b_sel    = 1'b0;
      d.wb_sel   = WB_ALU;
      d.rd_wren  = 1'b0;
      d.mem_rden = 1'b0;
      d.mem_wren = 1'b0;
      d.lsu_op   = 3'd0;
      d.illegal  = 1'b1;
    end
  end

  assign dec = d;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instr_dec feeding a 2-entry (main + skid) buffer, one-cycle latency, full throughput.
// Backpressure: output held while stalled; in_ready is a flop that drops once the skid entry fills.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1_addr,
  output logic [4:0]  out_rs2_addr,
  output logic [4:0]  out_rd_addr,
  output logic [3:0]  out_alu_op,
  output logic [2:0]  out_br_op,
  output logic        out_branch,
  output logic [1:0]  out_a_sel,
  output logic        out_b_sel,
  output logic [1:0]  out_wb_sel,
  output logic        out_rd_wren,
  output logic        out_mem_rden,
  output logic        out_mem_wren,
  output logic        out_illegal,
  output logic [2:0]  out_lsu_op
);

  dec_t   in_dec;
  entry_t in_ent;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_vld, main_vld_d, skid_vld, skid_vld_d;
  logic   in_ready_q;
  logic   acc, pop;

  instr_dec u_instr_dec (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign in_ent.pc  = in_pc;
  assign in_ent.dec = in_dec;

  assign in_ready = in_ready_q;
  assign acc      = in_valid & in_ready_q;
  assign pop      = main_vld & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld || pop) begin
      // Main slot frees up: the older skid entry always has priority over new input.
      if (skid_vld) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = acc;
        if (acc) main_d = in_ent;
      end
    end else if (acc) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld   <= main_vld_d;
      skid_vld   <= skid_vld_d;
      in_ready_q <= ~skid_vld_d;
    end
  end

  assign out_valid    = main_vld;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.dec.imm;
  assign out_rs1_addr = main_q.dec.rs1_addr;
  assign out_rs2_addr = main_q.dec.rs2_addr;
  assign out_rd_addr  = main_q.dec.rd_addr;
  assign out_alu_op   = main_q.dec.alu_op;
  assign out_br_op    = main_q.dec.br_op;
  assign out_branch   = main_q.dec.branch;
  assign out_a_sel    = main_q.dec.a_sel;
  assign out_b_sel    = main_q.dec.b_sel;
  assign out_wb_sel   = main_q.dec.wb_sel;
  assign out_rd_wren  = main_q.dec.rd_wren;
  assign out_mem_rden = main_q.dec.mem_rden;
  assign out_mem_wren = main_q.dec.mem_wren;
  assign out_illegal  = main_q.dec.illegal;
  assign out_lsu_op   = main_q.dec.lsu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed corner cases plus random traffic, checked by a queue scoreboard
// against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_br_op, out_lsu_op;
  logic        out_branch, out_b_sel, out_rd_wren, out_mem_rden, out_mem_wren, out_illegal;
  logic [1:0]  out_a_sel, out_wb_sel;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_alu_op(out_alu_op), .out_br_op(out_br_op), .out_branch(out_branch),
    .out_a_sel(out_a_sel), .out_b_sel(out_b_sel), .out_wb_sel(out_wb_sel),
    .out_rd_wren(out_rd_wren), .out_mem_rden(out_mem_rden), .out_mem_wren(out_mem_wren),
    .out_illegal(out_illegal), .out_lsu_op(out_lsu_op)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic        branch;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [1:0]  wb;
    logic        rd_wren, mem_rden, mem_wren, illegal;
    logic [2:0]  lsu;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp, held;
  logic hold_pend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // funct3 -> ALU code for non-alternate ops; funct3 -> branch code
  logic [3:0] alu_tab [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
  logic [2:0] br_tab  [8] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [6:0] op_tab  [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t o;
    o.pc = out_pc; o.imm = out_imm;
    o.rs1 = out_rs1_addr; o.rs2 = out_rs2_addr; o.rd = out_rd_addr;
    o.alu = out_alu_op; o.br = out_br_op; o.branch = out_branch;
    o.a_sel = out_a_sel; o.b_sel = out_b_sel; o.wb = out_wb_sel;
    o.rd_wren = out_rd_wren; o.mem_rden = out_mem_rden; o.mem_wren = out_mem_wren;
    o.illegal = out_illegal; o.lsu = out_lsu_op;
    return o;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, writes;
    e = '0;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1; writes = 0;
    case (ins[6:0])
      7'h37: begin e.a_sel = 2; e.b_sel = 1; e.imm = {ins[31:12], 12'h000}; writes = 1; end
      7'h17: begin e.a_sel = 1; e.b_sel = 1; e.imm = {ins[31:12], 12'h000}; writes = 1; end
      7'h6F: begin
        e.a_sel = 1; e.b_sel = 1; e.br = 6; e.branch = 1; e.wb = 2; writes = 1;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        ok = (f3 == 0); e.b_sel = 1; e.br = 7; e.branch = 1; e.wb = 2; writes = 1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h63: begin
        ok = (f3 != 2) && (f3 != 3); e.a_sel = 1; e.b_sel = 1; e.branch = 1; e.br = br_tab[f3];
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h03: begin
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        e.b_sel = 1; e.mem_rden = 1; e.wb = 1; e.lsu = f3; writes = 1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h23: begin
        ok = (f3 < 3); e.b_sel = 1; e.mem_wren = 1; e.lsu = f3;
        e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'h13: begin
        e.b_sel = 1; writes = 1;
        if (f3 == 1) begin
          ok = (f7 == 0); e.alu = 7; e.imm = {27'd0, ins[24:20]};
        end else if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20); e.alu = (f7 == 7'h20) ? 4'd9 : 4'd8;
          e.imm = {27'd0, ins[24:20]};
        end else begin
          e.alu = alu_tab[f3]; e.imm = 32'($signed(ins[31:20]));
        end
      end
      7'h33: begin
        writes = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        if (f7 == 7'h20) e.alu = (f3 == 0) ? 4'd1 : 4'd9;
        else e.alu = alu_tab[f3];
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0;
      e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.illegal = 1;
    end else begin
      e.rd_wren = writes && (e.rd != 0);
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = op_tab[k];
    if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return r;
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("hold_stable", {out_valid, dut_out()}, {1'b1, held});
      hold_pend = out_valid && !out_ready && !flush;
      held = dut_out();
      if (out_valid && out_ready && !flush) begin
        if (sb_q.size() == 0) check("spurious_output", out_valid, 1'b0);
        else begin
          mon_exp = sb_q.pop_front();
          check("decode", dut_out(), mon_exp);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_pc));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    bit took;
    n = 0; took = 0;
    in_valid = 1; in_instr = ins; in_pc = pc;
    while (!took && n < 50) begin
      @(negedge clk); took = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 0;
    if (!took) check("send_timeout", took, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit took;
    int n;
    in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_payload", dut_out(), '0);
    rst_n = 1;
    tick();
    check("in_ready_after_rst", in_ready, 1'b1);

    // Single instructions with known encodings
    out_ready = 1;
    send(32'h002081B3, 32'h0000_0100);
    check("add_latency", out_valid, 1'b1);
    check("add_fields", {out_alu_op, out_rs1_addr, out_rs2_addr, out_rd_addr, out_b_sel, out_rd_wren},
          {4'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1});
    tick();
    check("add_drained", out_valid, 1'b0);
    send(32'h40335293, 32'h0000_0104);
    check("srai_fields", {out_alu_op, out_imm, out_b_sel, out_rd_addr}, {4'd9, 32'h3, 1'b1, 5'd5});
    send(32'hFE20EEE3, 32'h0000_0108);
    check("bltu_fields", {out_br_op, out_branch, out_imm, out_a_sel, out_rd_wren},
          {3'd4, 1'b1, 32'hFFFF_FFFC, 2'd1, 1'b0});
    tick();

    // Backpressure: out_ready low for three edges, three back-to-back inputs
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h200;
    tick(); in_instr = 32'h00200113; in_pc = 32'h204;
    tick(); in_instr = 32'h00300193; in_pc = 32'h208;
    check("bp_in_ready_low", in_ready, 1'b0);
    tick();
    check("bp_out_first", {out_valid, out_pc}, {1'b1, 32'h200});
    out_ready = 1;
    tick();
    check("bp_in_ready_rise", in_ready, 1'b1);
    check("bp_out_second", out_pc, 32'h204);
    tick();
    in_valid = 0;
    check("bp_out_third", {out_valid, out_pc}, {1'b1, 32'h208});
    tick();

    // Flush with both entries full and an input offered
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00400213; in_pc = 32'h300;
    tick(); in_instr = 32'h00500293; in_pc = 32'h304;
    tick(); in_instr = 32'h00600313; in_pc = 32'h308; flush = 1;
    tick(); flush = 0; in_valid = 0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    // Flush while the input handshake completes: input must be dropped
    in_valid = 1; in_instr = 32'h00700393; in_pc = 32'h310;
    tick(); in_instr = 32'h00800413; in_pc = 32'h314; flush = 1;
    tick(); flush = 0; in_valid = 0;
    out_ready = 1;
    check("flush_drops_input", out_valid, 1'b0);
    tick();
    check("flush_stays_empty", out_valid, 1'b0);
    send(32'hFFFF_FFFF, 32'h400);
    check("illegal_after_flush",
          {out_valid, out_illegal, out_rd_wren, out_mem_rden, out_mem_wren, out_branch}, 6'b110000);
    tick();

    // Random traffic with random stalls and occasional flushes
    took = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = gen_instr();
        in_pc    = $urandom & 32'hFFFF_FFFC;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk); took = in_ready || flush;
      tick();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin tick(); n++; end
    check("drain_empty", sb_q.size(), 0);

    // Reset asserted mid-operation with both entries full
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00900493; in_pc = 32'h500;
    tick(); in_instr = 32'h00A00513; in_pc = 32'h504;
    tick(); in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_payload", dut_out(), '0);
    @(negedge clk); #1 rst_n = 1;
    tick();
    check("midrst_recover", {in_ready, out_valid}, 2'b10);
    out_ready = 1;
    send(32'h00B00593, 32'h600);
    check("post_rst_out", {out_valid, out_pc}, {1'b1, 32'h600});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
